// File: rtl/sdram_init_monitor_pkg.sv
// Shared SDRAM init definitions: command encodings, command classes, monitor
// states and violation codes, plus the mode-register legality helper.
package sdram_init_monitor_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ARF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_PRE   = 3'd1,
    CLS_ARF   = 3'd2,
    CLS_MRS   = 3'd3,
    CLS_OTHER = 3'd4
  } cmd_class_e;

  typedef enum logic [2:0] {
    ST_WAIT_PWR  = 3'd0,
    ST_WAIT_ARF1 = 3'd1,
    ST_WAIT_ARF2 = 3'd2,
    ST_WAIT_MRS  = 3'd3,
    ST_WAIT_MRD  = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_EARLY        = 3'd1;
  localparam logic [2:0] ERR_NOT_ALL_BANK = 3'd2;
  localparam logic [2:0] ERR_SEQUENCE     = 3'd3;
  localparam logic [2:0] ERR_TIMING       = 3'd4;
  localparam logic [2:0] ERR_BAD_MODE     = 3'd5;
  localparam logic [2:0] ERR_INIT_DONE    = 3'd6;

  // CAS latency must be 2 or 3; burst length 1/2/4/8 or full page
  function automatic logic mode_ok(input logic [2:0] cas_lat, input logic [2:0] burst_len);
    logic cl_ok;
    logic bl_ok;
    cl_ok = (cas_lat == 3'd2) || (cas_lat == 3'd3);
    case (burst_len)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd7: bl_ok = 1'b1;
      default:                      bl_ok = 1'b0;
    endcase
    return cl_ok && bl_ok;
  endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational classification of the {CS_N,RAS_N,CAS_N,WE_N} command bus.
module sdram_cmd_decode
  import sdram_init_monitor_pkg::*;
(
  input  logic [3:0] command,
  output cmd_class_e cmd_class
);

  // Deselected chip counts as NOP whatever the other strobes say
  always_comb begin
    cmd_class = CLS_OTHER;
    if (command[3]) begin
      cmd_class = CLS_NOP;
    end else begin
      case (command)
        CMD_NOP: cmd_class = CLS_NOP;
        CMD_PRE: cmd_class = CLS_PRE;
        CMD_ARF: cmd_class = CLS_ARF;
        CMD_MRS: cmd_class = CLS_MRS;
        default: cmd_class = CLS_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// Watches the SDRAM power-up sequence PRE-all, ARF, ARF, MRS and flags the first
// ordering/timing violation. Optional INIT_DONE check under `INIT_DONE_CHECK_EN.
module sdram_init_monitor
  import sdram_init_monitor_pkg::*;
#(
  parameter int unsigned TIME_WAIT_100US = 20000,
  parameter int unsigned T_RP            = 2,
  parameter int unsigned T_RFC           = 7,
  parameter int unsigned T_MRD           = 3
) (
  input  logic        Sys_clk,
  input  logic        Rst,
  input  logic [3:0]  COMMAND,
  input  logic [11:0] A_ADDR,
  input  logic [1:0]  BANK_ADDR,
`ifdef INIT_DONE_CHECK_EN
  input  logic        INIT_DONE,
`endif
  output logic        INIT_OK,
  output logic        INIT_ERR,
  output logic [2:0]  ERR_CODE,
  output logic [11:0] MODE_REG,
  output logic [2:0]  CAS_LAT,
  output logic [2:0]  BURST_LEN
);

  localparam logic [15:0] TW_C   = 16'(TIME_WAIT_100US);
  localparam logic [15:0] TRP_C  = 16'(T_RP);
  localparam logic [15:0] TRFC_C = 16'(T_RFC);
  localparam logic [15:0] TMRD_C = 16'(T_MRD);

  cmd_class_e  cls_s;
  cmd_class_e  want_s;
  logic        cmd_s;
  logic [15:0] gap_r;
  logic [15:0] min_gap_s;
  state_e      state_r;
  logic [2:0]  seq_viol_s;
  logic [2:0]  viol_s;
  logic        advance_s;
  logic        latch_s;
  logic        mrd_met_s;
  logic        unused_s;

  sdram_cmd_decode u_decode (
    .command   (COMMAND),
    .cmd_class (cls_s)
  );

  assign cmd_s     = (cls_s != CLS_NOP);
  assign mrd_met_s = (state_r == ST_WAIT_MRD) && (gap_r >= TMRD_C);
  assign unused_s  = ^BANK_ADDR;
  assign CAS_LAT   = MODE_REG[6:4];
  assign BURST_LEN = MODE_REG[2:0];

  // Cycles since the last command; the command cycle is gap 0, the next one gap 1
  always_ff @(posedge Sys_clk or posedge Rst) begin
    if (Rst) begin
      gap_r <= 16'd0;
    end else if (cmd_s) begin
      gap_r <= 16'd1;
    end else if (gap_r != 16'hFFFF) begin
      gap_r <= gap_r + 16'd1;
    end else begin
      gap_r <= gap_r;
    end
  end

  // Command expected next and the minimum gap it needs in each wait state
  always_comb begin
    want_s    = CLS_NOP;
    min_gap_s = 16'd0;
    case (state_r)
      ST_WAIT_PWR:  begin want_s = CLS_PRE; min_gap_s = TW_C;   end
      ST_WAIT_ARF1: begin want_s = CLS_ARF; min_gap_s = TRP_C;  end
      ST_WAIT_ARF2: begin want_s = CLS_ARF; min_gap_s = TRFC_C; end
      ST_WAIT_MRS:  begin want_s = CLS_MRS; min_gap_s = TRFC_C; end
      default:      begin want_s = CLS_NOP; min_gap_s = 16'd0;  end
    endcase
  end

  // Judge this cycle's command: timing before ordering, then the command's own fields
  always_comb begin
    seq_viol_s = ERR_NONE;
    advance_s  = 1'b0;
    latch_s    = 1'b0;
    if (state_r == ST_WAIT_MRD) begin
      if (mrd_met_s) begin
        advance_s = 1'b1;
      end else if (cmd_s) begin
        seq_viol_s = ERR_TIMING;
      end else begin
        advance_s = 1'b0;
      end
    end else if ((want_s != CLS_NOP) && cmd_s) begin
      if (gap_r < min_gap_s) begin
        seq_viol_s = (state_r == ST_WAIT_PWR) ? ERR_EARLY : ERR_TIMING;
      end else if (cls_s != want_s) begin
        seq_viol_s = ERR_SEQUENCE;
      end else if ((state_r == ST_WAIT_PWR) && !A_ADDR[10]) begin
        seq_viol_s = ERR_NOT_ALL_BANK;
      end else begin
        advance_s  = 1'b1;
        latch_s    = (state_r == ST_WAIT_MRS);
        seq_viol_s = (latch_s && !mode_ok(A_ADDR[6:4], A_ADDR[2:0])) ? ERR_BAD_MODE : ERR_NONE;
      end
    end else begin
      advance_s = 1'b0;
    end
  end

`ifdef INIT_DONE_CHECK_EN
  assign viol_s = ((seq_viol_s == ERR_NONE) && INIT_DONE && !mrd_met_s &&
                   (state_r != ST_DONE) && (state_r != ST_ERROR)) ? ERR_INIT_DONE : seq_viol_s;
`else
  assign viol_s = seq_viol_s;
`endif

  // Sequence FSM with registered status; ERROR and DONE hold until reset
  always_ff @(posedge Sys_clk or posedge Rst) begin
    if (Rst) begin
      state_r  <= ST_WAIT_PWR;
      INIT_OK  <= 1'b0;
      INIT_ERR <= 1'b0;
      ERR_CODE <= ERR_NONE;
      MODE_REG <= 12'd0;
    end else begin
      if (latch_s) begin
        MODE_REG <= A_ADDR;
      end
      if (viol_s != ERR_NONE) begin
        state_r  <= ST_ERROR;
        INIT_ERR <= 1'b1;
        INIT_OK  <= 1'b0;
        ERR_CODE <= viol_s;
      end else if (advance_s) begin
        case (state_r)
          ST_WAIT_PWR:  state_r <= ST_WAIT_ARF1;
          ST_WAIT_ARF1: state_r <= ST_WAIT_ARF2;
          ST_WAIT_ARF2: state_r <= ST_WAIT_MRS;
          ST_WAIT_MRS:  state_r <= ST_WAIT_MRD;
          ST_WAIT_MRD: begin
            state_r <= ST_DONE;
            INIT_OK <= 1'b1;
          end
          default:      state_r <= state_r;
        endcase
      end
    end
  end

endmodule

// File: doc/sdram_init_monitor.md
SDRAM_INIT_MONITOR -- requirements
Module: sdram_init_monitor

Interface
REQ-001 The module SHALL have parameter TIME_WAIT_100US, default 20000, the minimum power-up wait in cycles before the first command.
REQ-002 The module SHALL have parameter T_RP, default 2, the minimum PRE-to-ARF gap in cycles.
REQ-003 The module SHALL have parameter T_RFC, default 7, the minimum ARF-to-next-command gap in cycles.
REQ-004 The module SHALL have parameter T_MRD, default 3, the minimum MRS-to-done gap in cycles.
REQ-005 The module SHALL have port Sys_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 The module SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port COMMAND, input, 4 bits: {CS_N,RAS_N,CAS_N,WE_N} as driven by the init sequencer.
REQ-008 The module SHALL have port A_ADDR, input, 12 bits: the SDRAM address bus.
REQ-009 The module SHALL have port BANK_ADDR, input, 2 bits: the bank address, which is not checked.
REQ-010 The module SHALL have port INIT_OK, output, 1 bit: the sequence completed legally (sticky).
REQ-011 The module SHALL have port INIT_ERR, output, 1 bit: a violation was detected (sticky).
REQ-012 The module SHALL have port ERR_CODE, output, 3 bits: the first violation cause.
REQ-013 The module SHALL have port MODE_REG, output, 12 bits: the A_ADDR value latched at MRS.
REQ-014 The module SHALL have port CAS_LAT, output, 3 bits, equal to MODE_REG[6:4].
REQ-015 The module SHALL have port BURST_LEN, output, 3 bits, equal to MODE_REG[2:0].

Function
REQ-016 Command decode SHALL be: CS_N=1 or 0111 = NOP; 0010 = PRE; 0001 = ARF; 0000 = MRS; any other value = OTHER.
REQ-017 A 16-bit saturating gap counter SHALL clear to 0 on reset and on every accepted non-NOP command, and SHALL increment otherwise; a command in a given cycle is checked against the counter value in that cycle.
REQ-018 The state machine SHALL use the states WAIT_PWR, WAIT_ARF1, WAIT_ARF2, WAIT_MRS, WAIT_MRD, DONE and ERROR.
REQ-019 In WAIT_PWR, a non-NOP command with counter < TIME_WAIT_100US SHALL give ERROR with code 1 (early).
REQ-020 In WAIT_PWR, a PRE with counter >= TIME_WAIT_100US and A_ADDR[10]=1 SHALL move to WAIT_ARF1; a PRE with A_ADDR[10]=0 SHALL give code 2 (not all-bank).
REQ-021 In WAIT_ARF1, an ARF with counter >= T_RP SHALL move to WAIT_ARF2; an ARF with counter < T_RP SHALL give code 4 (timing).
REQ-022 In WAIT_ARF2, an ARF with counter >= T_RFC SHALL move to WAIT_MRS; an ARF with counter < T_RFC SHALL give code 4.
REQ-023 In WAIT_MRS, an MRS with counter >= T_RFC SHALL latch MODE_REG and move to WAIT_MRD; an MRS with counter < T_RFC SHALL give code 4.
REQ-024 In any WAIT state, a legal-timing but out-of-order non-NOP command SHALL give code 3 (sequence), except in WAIT_PWR, where REQ-019/REQ-020 apply.
REQ-025 At MRS, a CAS latency field not in {2,3}, or a burst length field not in {0,1,2,3,7}, SHALL give code 5 (bad mode); MODE_REG SHALL still latch the value.
REQ-026 In WAIT_MRD, INIT_OK SHALL assert registered in the cycle after the counter reaches T_MRD, moving to DONE; any non-NOP command before then SHALL give code 4.
REQ-027 In DONE, all commands SHALL be ignored and INIT_OK SHALL stay 1.
REQ-028 ERROR SHALL be terminal until reset, with INIT_ERR=1 and ERR_CODE frozen at the first cause; INIT_OK and INIT_ERR SHALL never both be 1.
REQ-029 All outputs SHALL be registered, and each violation SHALL be flagged one cycle after the offending command.

Reset
REQ-030 On Rst=1, at any time including mid-sequence, the block SHALL asynchronously enter WAIT_PWR with counter=0, INIT_OK=0, INIT_ERR=0, ERR_CODE=0 and MODE_REG=0.

Configuration
REQ-031 With INIT_DONE_CHECK_EN defined, the block SHALL add input INIT_DONE (1 bit), and INIT_DONE=1 in any state other than WAIT_MRD-at-T_MRD or DONE SHALL give code 6.
REQ-032 Without INIT_DONE_CHECK_EN, the INIT_DONE port SHALL be absent and code 6 SHALL never be produced.

Structure
REQ-033 The command encodings, state encoding and ERR_CODE values SHALL live in the shared SDRAM package/header used by the init sequencer.
REQ-034 The design SHALL consist of one optional sub-module, sdram_cmd_decode, containing the combinational COMMAND-to-class decode; everything else SHALL be in the top level.

Verification
REQ-035 With TIME_WAIT_100US=20, T_RP=2, T_RFC=7 and T_MRD=3, the bench SHALL drive PRE(A10=1)@20, ARF@22, ARF@29, MRS(A=0x032)@36 and NOP thereafter, and SHALL check INIT_OK=1 @40, CAS_LAT=3 and BURST_LEN=2.
REQ-036 The bench SHALL drive PRE@19 and check INIT_ERR=1 @20 with ERR_CODE=1.
REQ-037 The bench SHALL drive PRE@20 with A10=0 and check ERR_CODE=2.
REQ-038 The bench SHALL drive a legal PRE followed by ARF@21 and check ERR_CODE=4; separately, it SHALL drive MRS in place of the first ARF and check ERR_CODE=3.
REQ-039 The bench SHALL drive MRS with A=0x012 (CL=1) and check ERR_CODE=5; it SHALL then assert Rst at cycle 25 of a legal run and check all outputs return to 0 and a fresh legal sequence passes.
REQ-040 With INIT_DONE_CHECK_EN defined, the bench SHALL assert INIT_DONE @30 and check ERR_CODE=6; it SHALL assert INIT_DONE @39 and check that no error occurs.
